// File: rtl/fp_mul_pipe_param_if.sv
// Operand/result handshake bundle for fp_mul_pipe_param.
// The issue side drives the master modport; the multiplier uses the slave modport.
interface fp_mul_pipe_param_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_mul_pipe_param.sv
// Four-stage parametrised IEEE-754 multiplier with a stall-all valid/ready pipeline.
// Define FPMUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module fp_mul_pipe_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    fp_mul_pipe_param_if.slave bus
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int NW  = PW - 1;
    localparam int IE  = EXP_W + 3;
    localparam int LZW = $clog2(SW + 1);

    localparam logic signed [IE-1:0] E_ZERO  = '0;
    localparam logic signed [IE-1:0] E_ONE   = IE'(1);
    localparam logic signed [IE-1:0] E_BIAS  = IE'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [IE-1:0] E_MAX   = IE'(2 ** EXP_W - 1);
    localparam logic signed [IE-1:0] E_SHMAX = IE'(MAN_W + 3);

    typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3} rnd_e;

    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic                 inf;
        logic                 nan;
`ifdef FPMUL_FLAGS_EN
        logic                 snan;
`endif
        logic signed [IE-1:0] exp;
        logic [SW-1:0]        sig;
    } op_t;

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 inf;
        logic                 zero;
`ifdef FPMUL_FLAGS_EN
        logic                 inv;
`endif
        rnd_e                 rnd;
        logic signed [IE-1:0] expA;
        logic signed [IE-1:0] expB;
        logic [SW-1:0]        sigA;
        logic [SW-1:0]        sigB;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 inf;
        logic                 zero;
`ifdef FPMUL_FLAGS_EN
        logic                 inv;
`endif
        rnd_e                 rnd;
        logic signed [IE-1:0] exp;
        logic [PW-1:0]        prod;
    } s2_t;

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 inf;
        logic                 zero;
`ifdef FPMUL_FLAGS_EN
        logic                 inv;
        logic                 tiny;
`endif
        rnd_e                 rnd;
        logic signed [IE-1:0] exp;
        logic [SW-1:0]        man;
        logic                 g;
        logic                 r;
        logic                 s;
    } s3_t;

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = LZW'(SW - 1 - i);
        end
        return n;
    endfunction

    // Subnormals take exponent 1 and are left-justified so S2 always sees a leading one.
    function automatic op_t unpack(input logic [W-1:0] x);
        op_t              o;
        logic [EXP_W-1:0] ef;
        logic [MAN_W-1:0] mf;
        logic [SW-1:0]    sig;
        logic [LZW-1:0]   lz;
        logic [IE-1:0]    eb;
        logic             expZero;
        logic             expOnes;
        ef      = x[W-2 -: EXP_W];
        mf      = x[MAN_W-1:0];
        expZero = (ef == '0);
        expOnes = &ef;
        sig     = {!expZero, mf};
        lz      = lzc(sig);
        eb      = expZero ? IE'(1) : IE'(ef);
        o.sign  = x[W-1];
        o.zero  = expZero && (mf == '0);
        o.inf   = expOnes && (mf == '0);
        o.nan   = expOnes && (mf != '0);
`ifdef FPMUL_FLAGS_EN
        o.snan  = expOnes && (mf != '0) && !mf[MAN_W-1];
`endif
        o.sig   = sig << lz;
        o.exp   = $signed(eb - IE'(lz));
        return o;
    endfunction

    logic adv;
    logic s1Valid_q, s2Valid_q, s3Valid_q, outValid_q;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;
    logic [W-1:0] outData_d, outData_q;
    op_t  opA, opB;

    assign adv           = !outValid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;

    always_comb begin
        opA       = unpack(bus.a);
        opB       = unpack(bus.b);
        s1_d      = '0;
        s1_d.sign = opA.sign ^ opB.sign;
        s1_d.nan  = opA.nan || opB.nan || (opA.inf && opB.zero) || (opA.zero && opB.inf);
        s1_d.inf  = opA.inf || opB.inf;
        s1_d.zero = opA.zero || opB.zero;
`ifdef FPMUL_FLAGS_EN
        s1_d.inv  = opA.snan || opB.snan || (opA.inf && opB.zero) || (opA.zero && opB.inf);
`endif
        s1_d.rnd  = rnd_e'(bus.rnd_mode);
        s1_d.expA = opA.exp;
        s1_d.expB = opB.exp;
        s1_d.sigA = opA.sig;
        s1_d.sigB = opB.sig;
    end

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
`ifdef FPMUL_FLAGS_EN
        s2_d.inv  = s1_q.inv;
`endif
        s2_d.rnd  = s1_q.rnd;
        s2_d.exp  = s1_q.expA + s1_q.expB - E_BIAS;
        s2_d.prod = PW'(s1_q.sigA) * PW'(s1_q.sigB);
    end

    logic [NW-1:0]        norm, den, lostMask;
    logic                 stickyN, stickyD;
    logic signed [IE-1:0] expN, shRaw;
    logic [IE-1:0]        shAmt;

    // Hidden bit lands at bit NW-1; tiny results are shifted into the subnormal range with sticky collection.
    always_comb begin
        s3_d      = '0;
        s3_d.sign = s2_q.sign;
        s3_d.nan  = s2_q.nan;
        s3_d.inf  = s2_q.inf;
        s3_d.zero = s2_q.zero;
`ifdef FPMUL_FLAGS_EN
        s3_d.inv  = s2_q.inv;
`endif
        s3_d.rnd  = s2_q.rnd;
        norm      = s2_q.prod[PW-1] ? s2_q.prod[PW-1:1] : s2_q.prod[NW-1:0];
        stickyN   = s2_q.prod[PW-1] & s2_q.prod[0];
        expN      = s2_q.prod[PW-1] ? s2_q.exp + E_ONE : s2_q.exp;
        shRaw     = E_ONE - expN;
        shAmt     = (shRaw > E_SHMAX) ? E_SHMAX : shRaw;
        lostMask  = ~({NW{1'b1}} << shAmt);
        den       = norm;
        stickyD   = stickyN;
        s3_d.exp  = expN;
        if (expN < E_ONE) begin
            den      = norm >> shAmt;
            stickyD  = stickyN | (|(norm & lostMask));
            s3_d.exp = E_ZERO;
        end
`ifdef FPMUL_FLAGS_EN
        s3_d.tiny = (expN < E_ONE);
`endif
        s3_d.man  = den[NW-1 -: SW];
        s3_d.g    = den[MAN_W-1];
        s3_d.r    = den[MAN_W-2];
        s3_d.s    = stickyD | (|den[MAN_W-3:0]);
    end

    logic                 anyLost, inc, toInf, ovf;
    logic [SW:0]          mr;
    logic signed [IE-1:0] expR;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]           flags_d, flags_q;
    assign flags = flags_q;
`endif

    // A subnormal that rounds into the hidden bit becomes the smallest normal.
    always_comb begin
        anyLost = s3_q.g | s3_q.r | s3_q.s;
        inc     = 1'b0;
        unique case (s3_q.rnd)
            RNE: inc = s3_q.g & (s3_q.r | s3_q.s | s3_q.man[0]);
            RTZ: inc = 1'b0;
            RUP: inc = !s3_q.sign & anyLost;
            RDN: inc = s3_q.sign & anyLost;
        endcase
        mr   = {1'b0, s3_q.man} + {{SW{1'b0}}, inc};
        expR = s3_q.exp;
        if (mr[SW]) begin
            expR = s3_q.exp + E_ONE;
        end else if (s3_q.exp == E_ZERO && mr[MAN_W]) begin
            expR = E_ONE;
        end
        ovf   = (expR >= E_MAX);
        toInf = (s3_q.rnd == RNE) || (s3_q.rnd == RUP && !s3_q.sign) || (s3_q.rnd == RDN && s3_q.sign);
`ifdef FPMUL_FLAGS_EN
        flags_d = {1'b0, 1'b0, s3_q.tiny & anyLost, anyLost};
`endif
        if (s3_q.nan) begin
            outData_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (s3_q.inf) begin
            outData_d = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s3_q.zero) begin
            outData_d = {s3_q.sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end else if (ovf) begin
            outData_d = toInf ? {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                              : {s3_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            outData_d = {s3_q.sign, expR[EXP_W-1:0], mr[MAN_W-1:0]};
        end
`ifdef FPMUL_FLAGS_EN
        if (s3_q.nan || s3_q.inf || s3_q.zero) begin
            flags_d = {s3_q.inv, 3'b000};
        end else if (ovf) begin
            flags_d = 4'b0101;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s3Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
`ifdef FPMUL_FLAGS_EN
            flags_q    <= '0;
`endif
        end else if (adv) begin
            s1Valid_q  <= bus.in_valid;
            s2Valid_q  <= s1Valid_q;
            s3Valid_q  <= s2Valid_q;
            outValid_q <= s3Valid_q;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            outData_q  <= outData_d;
`ifdef FPMUL_FLAGS_EN
            flags_q    <= flags_d;
`endif
        end
    end
endmodule
